car_tracker: RTL

- Stage directly downstream of the per-step collision/move checker.
- Consumes the checker's 3-bit result {hit, move[1:0]} once per game step. Maintains the authoritative car lane position, remaining lives, score and game-over state.
- Its position output feeds back to the checker's position input and to the display renderer.

---
 rtl/car_dash_pkg.sv | 51 +++++
 rtl/car_tracker_flash_timer.sv | 35 +++
 rtl/car_tracker.sv | 119 +++++++++++
 3 files changed

// File: rtl/car_dash_pkg.sv
// Shared definitions for the car-dash game: lane geometry, move encodings,
// result bit layout and the game state type. Used by the collision checker,
// the car tracker and the display renderer.
package car_dash_pkg;

  // Lane geometry: lanes are numbered 0..MAX_POS, lane MAX_POS is leftmost.
  localparam int         NUM_LANES = 6;
  localparam logic [2:0] MAX_POS   = 3'(NUM_LANES - 1);

  // Direction field of the checker result.
  localparam logic [1:0] MOVE_NONE    = 2'b00;
  localparam logic [1:0] MOVE_LEFT    = 2'b10;
  localparam logic [1:0] MOVE_RIGHT   = 2'b01;
  localparam logic [1:0] MOVE_ILLEGAL = 2'b11;

  // Position of the collision flag inside the 3-bit checker result.
  localparam int HIT_BIT = 2;

  // Top-level game state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // Force any lane value back into the legal 0..MAX_POS range.
  function automatic logic [2:0] clamp_lane(input logic [2:0] lane);
    logic [2:0] result;
    result = (lane > MAX_POS) ? MAX_POS : lane;
    return result;
  endfunction

  // Lane after applying one move; moves saturate at the road edges and the
  // illegal encoding behaves like "stay".
  function automatic logic [2:0] next_lane(input logic [2:0] lane,
                                           input logic [1:0] dir);
    logic [2:0] cur;
    logic [2:0] result;
    cur    = clamp_lane(lane);
    result = cur;
    case (dir)
      MOVE_LEFT:    result = (cur == MAX_POS) ? cur : cur + 3'd1;
      MOVE_RIGHT:   result = (cur == 3'd0) ? cur : cur - 3'd1;
      MOVE_NONE:    result = cur;
      MOVE_ILLEGAL: result = cur;
      default:      result = cur;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/car_tracker_flash_timer.sv
// Retriggerable down-counter for timed visual effects. A load pulse restarts
// the count at FLASH_CYCLES, clear forces it to zero, and active is high
// while the count is non-zero. The count decrements on every clock.
module flash_timer #(
  parameter int FLASH_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  output logic active
);

  localparam int             CNT_W    = (FLASH_CYCLES < 1) ? 1 : $clog2(FLASH_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(FLASH_CYCLES);

  logic [CNT_W-1:0] count;

  // Clear beats load beats decrement; a load while running restarts the
  // full period rather than adding to what is left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign active = (count != '0);

endmodule

// File: rtl/car_tracker.sv
// Car tracker: consumes one checker result per game step and keeps the
// authoritative lane position, lives, score and game state. The position
// output loops back to the checker and also drives the renderer.
module car_tracker
  import car_dash_pkg::*;
#(
  parameter int START_POS    = 2,
  parameter int LIVES        = 3,
  parameter int FLASH_CYCLES = 8,
  parameter int SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               move_valid,
  input  logic [2:0]         move_result,
  output logic [2:0]         position,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               hit_flash,
  output logic               playing,
  output logic               game_over
);

  // Out-of-range start lanes are pulled back onto the road.
  localparam logic [2:0] START_LANE = (START_POS > int'(MAX_POS)) ? MAX_POS : 3'(START_POS);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  game_state_t        state;
  logic [2:0]         pos_q;
  logic [2:0]         lives_q;
  logic [SCORE_W-1:0] score_q;

  logic               hit;
  logic [1:0]         dir;
  logic               accept_start;
  logic               step;
  logic               step_hit;
  logic [2:0]         lane_next;
  logic [2:0]         lives_dec;
  logic               last_life;
  logic [SCORE_W-1:0] score_inc;

  assign hit = move_result[HIT_BIT];
  assign dir = move_result[1:0];

  // Derive the per-step update values: new lane, decremented lives and
  // incremented score, all saturating.
  always_comb begin
    accept_start = 1'b0;
    step         = 1'b0;
    lane_next    = next_lane(pos_q, dir);
    lives_dec    = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
    last_life    = (lives_q <= 3'd1);
    score_inc    = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
    if (state != PLAY) begin
      accept_start = start;
    end
    if (state == PLAY) begin
      step = move_valid;
    end
    step_hit = step && hit;
  end

  // Game state machine; a start outside PLAY reloads the game, and in PLAY
  // every move_valid cycle is one step (start is ignored mid-game).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pos_q   <= START_LANE;
      lives_q <= LIVES_INIT;
      score_q <= '0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (accept_start) begin
            state   <= PLAY;
            pos_q   <= START_LANE;
            lives_q <= LIVES_INIT;
            score_q <= '0;
          end
        end
        PLAY: begin
          if (step) begin
            pos_q <= lane_next;
            if (hit) begin
              lives_q <= lives_dec;
              if (last_life) begin
                state <= OVER;
              end
            end else begin
              score_q <= score_inc;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  flash_timer #(
    .FLASH_CYCLES(FLASH_CYCLES)
  ) u_flash (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept_start),
    .load    (step_hit),
    .active  (hit_flash)
  );

  assign position  = clamp_lane(pos_q);
  assign lives     = lives_q;
  assign score     = score_q;
  assign playing   = (state == PLAY);
  assign game_over = (state == OVER);

endmodule
